dtree_frame_loader: RTL

- Upstream/downstream wrapper for the combinational decision-tree classifier.
- Deserialises a byte-wide feature stream into a parallel feature bus that drives the tree's X inputs.
- Holds the bus stable for a programmable settle time, since printed combinational logic is slow.
- Captures the tree's class output and returns it over a valid/ready result port.
- One frame in flight; the tree itself is instantiated beside this block, not inside it.

---
 rtl/dtree_io_pkg.sv | 23 ++
 rtl/dtree_frame_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dtree_io_pkg.sv
// Shared types and default sizing for the decision-tree frame loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dtree_io_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam int FEAT_W = 8;
    localparam int N_FEAT = 20;
    localparam int CLS_W  = 2;

    // Slots X4 and X5 are not used by the tree, so their bytes are dropped
    localparam logic [N_FEAT-1:0] SKIP_MASK_DEF = 20'h00030;

    localparam int IDX_W = $clog2(N_FEAT);

endpackage

// File: rtl/dtree_frame_loader.sv
// Deserialises a byte stream into the tree's feature bus, waits for the tree to settle, returns the class.
// Latency: last byte accepted at edge T -> class captured at edge T+SETTLE_CYCLES -> m_valid from the following cycle.
// Backpressure: s_ready drops while settling or holding a result; the result is held until m_ready.
module dtree_frame_loader #(
    parameter int                               N_FEAT        = dtree_io_pkg::N_FEAT,
    parameter int                               W             = dtree_io_pkg::FEAT_W,
    parameter int                               CLS_W         = dtree_io_pkg::CLS_W,
    parameter logic [dtree_io_pkg::N_FEAT-1:0]  SKIP_MASK     = dtree_io_pkg::SKIP_MASK_DEF,
    parameter int                               SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W-1:0]        s_data,
    input  logic                s_last,
    output logic [N_FEAT*W-1:0] feat_bus,
    input  logic [CLS_W-1:0]    tree_class,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CLS_W-1:0]    m_class,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);
    import dtree_io_pkg::*;

    localparam int SLOT_W = $clog2(N_FEAT);

    state_t              state_q, state_d;
    logic [W-1:0]        feat_q [N_FEAT];
    logic [W-1:0]        feat_d [N_FEAT];
    logic [SLOT_W-1:0]   idx_q, idx_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [CLS_W-1:0]    m_class_q, m_class_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                acc;

    // Bytes are taken only while filling or draining, and never during reset
    assign s_ready = ~rst & ((state_q == LOAD) | (state_q == DRAIN));
    assign acc     = s_valid & s_ready;

    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

    for (genvar g = 0; g < N_FEAT; g++) begin : g_bus
        assign feat_bus[g*W +: W] = feat_q[g];
    end

    // Next-state logic: slot fill, length checking, settle countdown and result handshake
    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_class_d   = m_class_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            LOAD: begin
                if (acc) begin
                    if (!SKIP_MASK[idx_q]) begin
                        feat_d[idx_q] = s_data;
                    end
                    if (idx_q == SLOT_W'(N_FEAT - 1)) begin
                        idx_d = '0;
                        if (s_last) begin
                            cnt_d   = 8'(SETTLE_CYCLES - 1);
                            state_d = SETTLE;
                        end else begin
                            // Overlong frame: flag it and swallow the tail
                            frame_err_d = 1'b1;
                            state_d     = DRAIN;
                        end
                    end else if (s_last) begin
                        // Short frame: flag it and restart; stale slots get overwritten next frame
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (acc && s_last) begin
                    state_d = LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    m_class_d   = tree_class;
                    m_valid_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            OUT: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State register; a synchronous reset drops any frame or pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            for (int i = 0; i < N_FEAT; i++) begin
                feat_q[i] <= '0;
            end
            idx_q       <= '0;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            m_class_q   <= m_class_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
